// File: rtl/alu_sequencer.sv
// Round-robin sequencer in front of a shared combinational 8-bit ALU.
// Arbitrates two requesters, iterates multi-bit shifts one bit per cycle, and returns tagged responses.
module alu_sequencer #(
    parameter int MAX_SHIFT = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_op,
    input  logic       req0_mode,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req0_num,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_op,
    input  logic       req1_mode,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [7:0] req1_num,
    output logic       alu_en,
    output logic [2:0] alu_op,
    output logic [7:0] alu_data_a,
    output logic [7:0] alu_data_b,
    output logic [7:0] alu_num,
    output logic [7:0] alu_put,
    output logic       alu_lsr,
    output logic       alu_cmp_imm,
    output logic [7:0] alu_load,
    input  logic [7:0] alu_rslt,
    input  logic       alu_grt,
    input  logic       alu_lss,
    input  logic       alu_eql,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_rslt,
    output logic       flag_grt,
    output logic       flag_lss,
    output logic       flag_eql,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [2:0] OP_SHIFT = 3'b100;
    localparam logic [2:0] OP_CMP   = 3'b101;
    localparam logic [2:0] OP_FLIP  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    localparam logic [7:0] MAX_SHIFT_U8 = 8'(MAX_SHIFT);

    logic [1:0] state_reg;
    logic       ptr_reg;
    logic [2:0] op_reg;
    logic       mode_reg;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] num_reg;
    logic       id_reg;
    logic [7:0] cnt_reg;
    logic [7:0] acc_reg;
    logic [7:0] rslt_reg;
    logic       grt_reg;
    logic       lss_reg;
    logic       eql_reg;

    logic       grant0;
    logic       grant1;
    logic       accept;
    logic [2:0] sel_op;
    logic       sel_mode;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [7:0] sel_num;

    // Ready is gated by reset so nothing looks accepted while the block is held in reset.
    always_comb begin
        grant0   = Reset_n && (state_reg == ST_IDLE) && req0_valid && (!req1_valid || !ptr_reg);
        grant1   = Reset_n && (state_reg == ST_IDLE) && req1_valid && (!req0_valid || ptr_reg);
        accept   = grant0 || grant1;
        sel_op   = grant1 ? req1_op   : req0_op;
        sel_mode = grant1 ? req1_mode : req0_mode;
        sel_a    = grant1 ? req1_a    : req0_a;
        sel_b    = grant1 ? req1_b    : req0_b;
        sel_num  = grant1 ? req1_num  : req0_num;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= 1'b0;
            op_reg    <= '0;
            mode_reg  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            num_reg   <= '0;
            id_reg    <= 1'b0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            rslt_reg  <= '0;
            grt_reg   <= 1'b0;
            lss_reg   <= 1'b0;
            eql_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg   <= sel_op;
                        mode_reg <= sel_mode;
                        a_reg    <= sel_a;
                        b_reg    <= sel_b;
                        num_reg  <= sel_num;
                        id_reg   <= grant1;
                        ptr_reg  <= !grant1;
                        // A zero-length shift is a plain pass-through through the ALU.
                        if (sel_op == OP_SHIFT && sel_b != 8'd0) begin
                            cnt_reg   <= (sel_b > MAX_SHIFT_U8) ? MAX_SHIFT_U8 : sel_b;
                            acc_reg   <= sel_a;
                            state_reg <= ST_SHIFT;
                        end else begin
                            state_reg <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    rslt_reg <= (op_reg == OP_RSVD) ? 8'd0 : alu_rslt;
                    if (op_reg == OP_CMP) begin
                        grt_reg <= alu_grt;
                        lss_reg <= alu_lss;
                        eql_reg <= alu_eql;
                    end else if (op_reg == OP_FLIP) begin
                        grt_reg <= 1'b0;
                        lss_reg <= 1'b0;
                        eql_reg <= 1'b0;
                    end
                    state_reg <= ST_RESP;
                end
                ST_SHIFT: begin
                    acc_reg <= alu_rslt;
                    cnt_reg <= cnt_reg - 8'd1;
                    if (cnt_reg == 8'd1) begin
                        rslt_reg  <= alu_rslt;
                        state_reg <= ST_RESP;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Single-bit steps during SHIFT feed the accumulator back as operand A.
    always_comb begin
        alu_en      = 1'b0;
        alu_op      = '0;
        alu_data_a  = '0;
        alu_data_b  = '0;
        alu_num     = '0;
        alu_put     = '0;
        alu_lsr     = 1'b0;
        alu_cmp_imm = 1'b0;
        case (state_reg)
            ST_EXEC: begin
                alu_en      = 1'b1;
                alu_op      = op_reg;
                alu_data_a  = a_reg;
                alu_data_b  = b_reg;
                alu_num     = num_reg;
                alu_put     = num_reg;
                alu_lsr     = (op_reg == OP_SHIFT) && mode_reg;
                alu_cmp_imm = (op_reg == OP_CMP) && mode_reg;
            end
            ST_SHIFT: begin
                alu_en     = 1'b1;
                alu_op     = OP_SHIFT;
                alu_data_a = acc_reg;
                alu_data_b = 8'd1;
                alu_lsr    = mode_reg;
            end
            default: begin
            end
        endcase
    end

    assign alu_load  = '0;
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_id    = id_reg;
    assign rsp_rslt  = rslt_reg;
    assign flag_grt  = grt_reg;
    assign flag_lss  = lss_reg;
    assign flag_eql  = eql_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a stub ALU drives the result path, a spec-level model predicts responses.
module tb_alu_sequencer;

    localparam int MAX_SHIFT = 8;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_op = '0, req1_op = '0;
    logic       req0_mode = 1'b0, req1_mode = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req0_num = '0;
    logic [7:0] req1_a = '0, req1_b = '0, req1_num = '0;
    logic       alu_en;
    logic [2:0] alu_op;
    logic [7:0] alu_data_a, alu_data_b, alu_num, alu_put, alu_load;
    logic       alu_lsr, alu_cmp_imm;
    logic [7:0] alu_rslt;
    logic       alu_grt, alu_lss, alu_eql;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [7:0] rsp_rslt;
    logic       flag_grt, flag_lss, flag_eql;
    logic       busy;

    alu_sequencer #(.MAX_SHIFT(MAX_SHIFT)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_mode(req0_mode),
        .req0_a(req0_a), .req0_b(req0_b), .req0_num(req0_num),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_mode(req1_mode),
        .req1_a(req1_a), .req1_b(req1_b), .req1_num(req1_num),
        .alu_en(alu_en), .alu_op(alu_op), .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
        .alu_num(alu_num), .alu_put(alu_put), .alu_lsr(alu_lsr), .alu_cmp_imm(alu_cmp_imm),
        .alu_load(alu_load), .alu_rslt(alu_rslt), .alu_grt(alu_grt), .alu_lss(alu_lss), .alu_eql(alu_eql),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rslt(rsp_rslt),
        .flag_grt(flag_grt), .flag_lss(flag_lss), .flag_eql(flag_eql), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Stub of the shared ALU; flags always reflect A against the compare operand.
    logic [7:0] stub_opnd;
    always_comb begin
        alu_rslt  = '0;
        alu_grt   = 1'b0;
        alu_lss   = 1'b0;
        alu_eql   = 1'b0;
        stub_opnd = alu_cmp_imm ? alu_num : alu_data_b;
        if (alu_en) begin
            alu_grt = alu_data_a > stub_opnd;
            alu_lss = alu_data_a < stub_opnd;
            alu_eql = alu_data_a == stub_opnd;
            case (alu_op)
                3'd0: alu_rslt = alu_data_a;
                3'd1: alu_rslt = alu_put;
                3'd2: alu_rslt = alu_data_a + alu_data_b;
                3'd3: alu_rslt = alu_data_a - alu_data_b;
                3'd4: alu_rslt = alu_lsr ? (alu_data_a >> alu_data_b) : (alu_data_a << alu_data_b);
                3'd5: alu_rslt = alu_data_a - stub_opnd;
                3'd6: alu_rslt = ~alu_data_a;
                default: alu_rslt = 8'hA5;
            endcase
        end
    end

    typedef struct {
        logic       id;
        logic [7:0] rslt;
        logic [2:0] flags;
        int         lat;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   glog[$];

    logic       m_ptr = 1'b0;
    logic [2:0] m_flags = '0;
    logic       m_busy = 1'b0;
    int         m_resp_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Spec-level result: shifts are a single shift by the clamped amount.
    function automatic logic [7:0] ref_rslt(input logic [2:0] op, input logic mode,
                                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] num);
        int         n;
        logic [7:0] x;
        x = mode ? num : b;
        n = (int'(b) > MAX_SHIFT) ? MAX_SHIFT : int'(b);
        case (op)
            3'd0: return a;
            3'd1: return num;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return mode ? 8'(a >> n) : 8'(a << n);
            3'd5: return a - x;
            3'd6: return ~a;
            default: return 8'd0;
        endcase
    endfunction

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    // Accept observer: checks arbitration and idle behaviour, pushes expectations on accept.
    initial forever begin : acceptor
        logic       e0, e1, id;
        logic [2:0] op;
        logic       mode;
        logic [7:0] a, b, num, x;
        exp_t       e;
        @(negedge Clk);
        if (!Reset_n) begin
            chk("reset_outputs", {rsp_valid, rsp_id, rsp_rslt, flag_grt, flag_lss, flag_eql, busy,
                                  req0_ready, req1_ready, alu_en, alu_op, alu_data_a, alu_data_b,
                                  alu_num, alu_put, alu_lsr, alu_cmp_imm, alu_load}, 64'd0);
            sb.delete();
            m_ptr   = 1'b0;
            m_flags = '0;
            m_busy  = 1'b0;
        end else begin
            e0 = !m_busy && req0_valid && (!req1_valid || m_ptr == 1'b0);
            e1 = !m_busy && req1_valid && (!req0_valid || m_ptr == 1'b1);
            chk("ready_grant", {req1_ready, req0_ready}, {e1, e0});
            chk("busy", busy, m_busy);
            chk("rsp_valid_timing", rsp_valid, m_busy && cyc >= m_resp_cyc);
            if (!m_busy || cyc >= m_resp_cyc)
                chk("alu_inputs_idle", {alu_en, alu_op, alu_data_a, alu_data_b, alu_num, alu_put,
                                        alu_lsr, alu_cmp_imm}, 64'd0);
            if (e0 || e1) begin
                id   = e1;
                op   = id ? req1_op   : req0_op;
                mode = id ? req1_mode : req0_mode;
                a    = id ? req1_a    : req0_a;
                b    = id ? req1_b    : req0_b;
                num  = id ? req1_num  : req0_num;
                x    = mode ? num : b;
                if (op == 3'd5)      m_flags = {a > x, a < x, a == x};
                else if (op == 3'd6) m_flags = 3'b000;
                e.id      = id;
                e.rslt    = ref_rslt(op, mode, a, b, num);
                e.flags   = m_flags;
                e.lat     = (op == 3'd4 && b != 8'd0) ? ((int'(b) > MAX_SHIFT) ? MAX_SHIFT : int'(b)) : 1;
                e.acc_cyc = cyc;
                sb.push_back(e);
                m_ptr      = !id;
                m_busy     = 1'b1;
                m_resp_cyc = cyc + e.lat + 1;
            end else if (m_busy && cyc >= m_resp_cyc && rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // Response monitor: pops on the first cycle of each response, then checks it holds under backpressure.
    initial forever begin : monitor
        logic resp_active;
        exp_t cur;
        resp_active = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                resp_active = 1'b0;
            end else if (rsp_valid) begin
                if (!resp_active) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 id=%0d rslt=0x%0h required no response", rsp_id, rsp_rslt);
                    end else begin
                        cur = sb.pop_front();
                        chk("rsp_id", rsp_id, cur.id);
                        chk("rsp_rslt", rsp_rslt, cur.rslt);
                        chk("rsp_flags", {flag_grt, flag_lss, flag_eql}, cur.flags);
                        chk("rsp_latency", cyc - cur.acc_cyc - 1, cur.lat);
                        $display("rsp id=%0d rslt=0x%02h flags=%03b lat=%0d", rsp_id, rsp_rslt,
                                 {flag_grt, flag_lss, flag_eql}, cyc - cur.acc_cyc - 1);
                    end
                    resp_active = 1'b1;
                end else begin
                    chk("hold_rslt", rsp_rslt, cur.rslt);
                    chk("hold_id_flags", {rsp_id, flag_grt, flag_lss, flag_eql}, {cur.id, cur.flags});
                    chk("hold_readys", {req1_ready, req0_ready}, 2'b00);
                end
                if (rsp_ready) resp_active = 1'b0;
            end
        end
    end

    task automatic set_req(input logic id, input logic v, input logic [2:0] op, input logic mode,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] num);
        if (id == 1'b0) begin
            req0_valid = v; req0_op = op; req0_mode = mode; req0_a = a; req0_b = b; req0_num = num;
        end else begin
            req1_valid = v; req1_op = op; req1_mode = mode; req1_a = a; req1_b = b; req1_num = num;
        end
    endtask

    task automatic rand_req(input logic id);
        logic [2:0] op;
        op = 3'($urandom_range(0, 7));
        set_req(id, 1'b1, op, 1'($urandom_range(0, 1)), 8'($urandom),
                (op == 3'd4) ? 8'($urandom_range(0, 11)) : 8'($urandom), 8'($urandom));
    endtask

    task automatic issue(input logic id, input logic [2:0] op, input logic mode, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] num, output int waits);
        logic got;
        got   = 1'b0;
        waits = 0;
        set_req(id, 1'b1, op, mode, a, b, num);
        while (!got && waits < 100) begin
            @(negedge Clk);
            waits++;
            got = id ? req1_ready : req0_ready;
        end
        chk("accept_timeout", got, 1'b1);
        $display("req id=%0d op=%0d mode=%0d a=0x%02h b=0x%02h num=0x%02h waits=%0d", id, op, mode, a, b, num, waits);
        @(posedge Clk);
        #1;
        if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge Clk);
        while (busy && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
        @(posedge Clk);
        #1;
    endtask

    initial begin : stim
        int w, accepts, n, zeros;
        logic g0, g1;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        issue(1'b0, 3'd2, 1'b0, 8'hF0, 8'h20, 8'h00, w);
        wait_idle();
        chk("add_wrap", {rsp_id, rsp_rslt, flag_grt, flag_lss, flag_eql}, {1'b0, 8'h10, 3'b000});

        issue(1'b1, 3'd4, 1'b0, 8'h03, 8'd3, 8'h00, w);
        wait_idle();
        chk("shl3", {rsp_id, rsp_rslt}, {1'b1, 8'h18});
        issue(1'b0, 3'd4, 1'b1, 8'h80, 8'd9, 8'h00, w);
        wait_idle();
        chk("shr_clamped", rsp_rslt, 8'h00);
        issue(1'b1, 3'd4, 1'b0, 8'h5A, 8'd0, 8'h00, w);
        wait_idle();
        chk("shift_zero", rsp_rslt, 8'h5A);

        issue(1'b0, 3'd5, 1'b1, 8'd5, 8'd2, 8'd9, w);
        wait_idle();
        chk("cmp_flags", {flag_grt, flag_lss, flag_eql}, 3'b010);
        issue(1'b1, 3'd2, 1'b0, 8'd1, 8'd1, 8'd0, w);
        wait_idle();
        chk("add_flags_hold", {rsp_rslt, flag_grt, flag_lss, flag_eql}, {8'd2, 3'b010});
        issue(1'b0, 3'd6, 1'b0, 8'h0F, 8'h00, 8'h00, w);
        wait_idle();
        chk("flip", {rsp_rslt, flag_grt, flag_lss, flag_eql}, {8'hF0, 3'b000});

        rsp_ready = 1'b0;
        issue(1'b1, 3'd3, 1'b0, 8'h10, 8'h20, 8'h00, w);
        repeat (5) @(posedge Clk);
        #1;
        chk("bp_still_resp", {rsp_valid, busy, rsp_rslt}, {2'b11, 8'hF0});
        rsp_ready = 1'b1;
        wait_idle();

        issue(1'b0, 3'd4, 1'b0, 8'h01, 8'd5, 8'h00, w);
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        issue(1'b0, 3'd2, 1'b0, 8'h33, 8'h44, 8'h00, w);
        chk("fresh_accept_wait", w, 1);
        wait_idle();
        chk("after_reset_add", {rsp_rslt, flag_grt, flag_lss, flag_eql}, {8'h77, 3'b000});

        // Both requesters held valid continuously from reset.
        Reset_n = 1'b0;
        rand_req(1'b0);
        rand_req(1'b1);
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        accepts = 0;
        n = 0;
        while (accepts < 20 && n < 2000) begin
            @(negedge Clk);
            g0 = req0_valid && req0_ready;
            g1 = req1_valid && req1_ready;
            @(posedge Clk);
            #1;
            if (g0) begin glog.push_back(0); accepts++; rand_req(1'b0); end
            if (g1) begin glog.push_back(1); accepts++; rand_req(1'b1); end
            rsp_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        chk("fair_accepts", accepts, 20);
        zeros = 0;
        for (int i = 0; i < glog.size(); i++) begin
            if (glog[i] == 0) zeros++;
            if (i > 0) chk("grant_alternate", glog[i] != glog[i-1], 1'b1);
        end
        chk("grant_count0", zeros, 10);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        wait_idle();
        @(negedge Clk);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
